retire_ctrl: RTL and testbench
==============================

Name: retire_ctrl

Overview:
- Commit/retire sequencer between the ROB head and the retirement RAT (RRAT), the PRF free list, the LSQ and the front-end RAT.
- Each cycle it decides how many of the two oldest ROB entries (0, 1 or 2) retire, and drives the RRAT commit strobes and the free-list returns.
- Serialises store retirement with an LSQ handshake.
- On a mispredicting branch it runs a multi-cycle recovery that flushes the pipeline and copies the RRAT into the RAT chunk by chunk.

Parameters:
ARF_SIZE, 32, number of architectural registers
ARF_IDX, 5, log2(ARF_SIZE)
PRF_IDX, 6, physical register index width
CHUNK, 8, RAT entries restored per recovery cycle; must divide ARF_SIZE

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
rob_valid_1  in  1  head entry (slot 1) occupied
rob_done_1  in  1  slot 1 has completed execution
rob_has_dest_1  in  1  slot 1 writes a non-zero arch reg
rob_dest_1  in  ARF_IDX  slot 1 arch dest
rob_prf_1  in  PRF_IDX  slot 1 new PRF mapping
rob_old_prf_1  in  PRF_IDX  slot 1 previous mapping, to be freed
rob_store_1 / rob_mispred_1 / rob_halt_1  in  1 each  slot 1 is a store / mispredicted branch / halt
rob_*_2  in  same widths  identical set for head+1 (slot 2)
store_ack  in  1  LSQ has written the committed store to the cache
commit_en_1, commit_en_2  out  1  RRAT update strobes
rrat_dest_1/2  out  ARF_IDX  equal to rob_dest_1/2
rrat_prf_1/2  out  PRF_IDX  equal to rob_prf_1/2
free_en_1, free_en_2  out  1  return old PRF to the free list
free_prf_1/2  out  PRF_IDX  equal to rob_old_prf_1/2
retire_cnt  out  2  ROB head advance this cycle (0..2)
store_commit  out  1  one-cycle pulse: LSQ begins head store
flush  out  1  squash all in-flight work
rat_restore_en  out  1  RAT copies RRAT entries [rat_restore_base, rat_restore_base+CHUNK-1]
rat_restore_base  out  ARF_IDX  first entry of current chunk
halted  out  1  sticky halt indication

Behaviour:
- States: NORMAL, ST_WAIT, RECOVER, HALTED.
- Reset (async) → NORMAL, chunk counter 0. All outputs 0, except the combinational pass-through buses, which follow their inputs.
- Strobes and counts are combinational from state + ROB inputs. RRAT and free list sample them at the next rising edge.
- free_en_k = commit_en_k & rob_has_dest_k.
- retire_cnt = commit_en_1 + commit_en_2.
- NORMAL:
  - c1 = rob_valid_1 & rob_done_1 & !rob_store_1.
  - Slot 1 store (valid & done): store_commit = 1 for exactly one cycle, no commit, → ST_WAIT.
  - commit_en_1 = c1.
  - commit_en_2 = c1 & !rob_mispred_1 & !rob_halt_1 & rob_valid_2 & rob_done_2 & !rob_store_2 & !rob_halt_2.
  - Consequence: a slot 2 store or slot 2 halt always waits to become slot 1.
- NORMAL transitions:
  - Committed slot 1 has mispred → RECOVER.
  - Else committed slot 2 has mispred → RECOVER.
  - Else committed slot 1 has halt → HALTED.
- ST_WAIT:
  - No commits while store_ack = 0.
  - Cycle with store_ack = 1: commit_en_1 = 1 (slot 1 only), then → NORMAL.
  - store_ack outside ST_WAIT is ignored.
- RECOVER:
  - flush = 1 and rat_restore_en = 1 every cycle; commit_en_* = 0; retire_cnt = 0.
  - rat_restore_base = counter * CHUNK, counter starting at 0.
  - Lasts exactly ARF_SIZE/CHUNK cycles (4 at default); the RAT restore is then complete.
  - After the last chunk: counter → 0, → NORMAL.
  - Entry cycle: the committing mispredict's RRAT write lands at the same edge as the state change, so the first restore cycle already sees the updated RRAT.
- HALTED: no commits, no flush, halted = 1 until reset.
- Same-dest double commit: both strobes are asserted; the RRAT gives slot 2 priority. Both old PRFs are freed.
- Reset mid-RECOVER or mid-ST_WAIT: immediate abort to NORMAL, counter cleared.

Test Plan:
1. Slots 1/2 both valid, done, dest 3/7, prf 40/41, old 3/7 → commit_en_1 = commit_en_2 = 1, retire_cnt = 2, free_prf 3/7; next cycle, RRAT[3] = 40, RRAT[7] = 41.
2. Slot 1 done, slot 2 not done → retire_cnt = 1, commit_en_2 = 0. Slot 1 not done, slot 2 done → retire_cnt = 0.
3. Slot 1 store done → store_commit pulse in cycle 0, commit_en_1 = 0. store_ack held 0 for 3 cycles, then 1 → commit_en_1 = 1 in exactly that cycle, then NORMAL.
4. Slot 1 mispred (dest 5, prf 50) with slot 2 ready → only slot 1 commits. flush = 1 for 4 cycles with rat_restore_base 0, 8, 16, 24, then NORMAL and commits resume.
5. Slot 2 mispred → both commit, then recovery. Reset asserted after restore chunk 8 → outputs 0 asynchronously; after release, state is NORMAL with base 0.
6. Slot 1 halt with slot 2 ready → only slot 1 commits, halted = 1 from the next cycle. Later ready entries are never committed until reset.

Source files
------------

// File: rtl/retire_ctrl_if.sv
// Retire controller bus: ROB head pair and LSQ ack in,
// RRAT/free-list strobes and recovery control out.
interface retire_ctrl_if #(
    parameter int ARF_IDX = 5,
    parameter int PRF_IDX = 6
);
    logic               rob_valid_1;
    logic               rob_done_1;
    logic               rob_has_dest_1;
    logic [ARF_IDX-1:0] rob_dest_1;
    logic [PRF_IDX-1:0] rob_prf_1;
    logic [PRF_IDX-1:0] rob_old_prf_1;
    logic               rob_store_1;
    logic               rob_mispred_1;
    logic               rob_halt_1;
    logic               rob_valid_2;
    logic               rob_done_2;
    logic               rob_has_dest_2;
    logic [ARF_IDX-1:0] rob_dest_2;
    logic [PRF_IDX-1:0] rob_prf_2;
    logic [PRF_IDX-1:0] rob_old_prf_2;
    logic               rob_store_2;
    logic               rob_mispred_2;
    logic               rob_halt_2;
    logic               store_ack;

    logic               commit_en_1;
    logic               commit_en_2;
    logic [ARF_IDX-1:0] rrat_dest_1;
    logic [ARF_IDX-1:0] rrat_dest_2;
    logic [PRF_IDX-1:0] rrat_prf_1;
    logic [PRF_IDX-1:0] rrat_prf_2;
    logic               free_en_1;
    logic               free_en_2;
    logic [PRF_IDX-1:0] free_prf_1;
    logic [PRF_IDX-1:0] free_prf_2;
    logic [1:0]         retire_cnt;
    logic               store_commit;
    logic               flush;
    logic               rat_restore_en;
    logic [ARF_IDX-1:0] rat_restore_base;
    logic               halted;

    modport master (
        input  rob_valid_1, rob_done_1, rob_has_dest_1, rob_dest_1,
        input  rob_prf_1, rob_old_prf_1, rob_store_1, rob_mispred_1,
        input  rob_halt_1,
        input  rob_valid_2, rob_done_2, rob_has_dest_2, rob_dest_2,
        input  rob_prf_2, rob_old_prf_2, rob_store_2, rob_mispred_2,
        input  rob_halt_2,
        input  store_ack,
        output commit_en_1, commit_en_2, rrat_dest_1, rrat_dest_2,
        output rrat_prf_1, rrat_prf_2, free_en_1, free_en_2,
        output free_prf_1, free_prf_2, retire_cnt, store_commit,
        output flush, rat_restore_en, rat_restore_base, halted
    );

    modport slave (
        output rob_valid_1, rob_done_1, rob_has_dest_1, rob_dest_1,
        output rob_prf_1, rob_old_prf_1, rob_store_1, rob_mispred_1,
        output rob_halt_1,
        output rob_valid_2, rob_done_2, rob_has_dest_2, rob_dest_2,
        output rob_prf_2, rob_old_prf_2, rob_store_2, rob_mispred_2,
        output rob_halt_2,
        output store_ack,
        input  commit_en_1, commit_en_2, rrat_dest_1, rrat_dest_2,
        input  rrat_prf_1, rrat_prf_2, free_en_1, free_en_2,
        input  free_prf_1, free_prf_2, retire_cnt, store_commit,
        input  flush, rat_restore_en, rat_restore_base, halted
    );
endinterface

// File: rtl/retire_ctrl.sv
// Two-wide retire sequencer: RRAT commit, free-list return,
// store serialisation and chunked RRAT->RAT recovery.
module retire_ctrl #(
    parameter int ARF_SIZE = 32,
    parameter int ARF_IDX  = 5,
    parameter int PRF_IDX  = 6,
    parameter int CHUNK    = 8
) (
    input  logic         clock,
    input  logic         reset,
    retire_ctrl_if.master bus
);
    localparam int NCH = ARF_SIZE / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {NORMAL, ST_WAIT, RECOVER, HALTED} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          flush_q;
    logic          halted_q;
    logic          c1;
    logic          c2;
    logic          st;

    // Strobes are gated by reset so they drop asynchronously too.
    always_comb begin
        c1 = 1'b0;
        c2 = 1'b0;
        st = 1'b0;
        if (!reset) begin
            unique case (state)
                NORMAL: begin
                    st = bus.rob_valid_1 & bus.rob_done_1 & bus.rob_store_1;
                    c1 = bus.rob_valid_1 & bus.rob_done_1 & !bus.rob_store_1;
                    c2 = c1 & !bus.rob_mispred_1 & !bus.rob_halt_1
                       & bus.rob_valid_2 & bus.rob_done_2
                       & !bus.rob_store_2 & !bus.rob_halt_2;
                end
                ST_WAIT: c1 = bus.store_ack;
                default: ;
            endcase
        end
    end

    assign bus.commit_en_1      = c1;
    assign bus.commit_en_2      = c2;
    assign bus.free_en_1        = c1 & bus.rob_has_dest_1;
    assign bus.free_en_2        = c2 & bus.rob_has_dest_2;
    assign bus.rrat_dest_1      = bus.rob_dest_1;
    assign bus.rrat_dest_2      = bus.rob_dest_2;
    assign bus.rrat_prf_1       = bus.rob_prf_1;
    assign bus.rrat_prf_2       = bus.rob_prf_2;
    assign bus.free_prf_1       = bus.rob_old_prf_1;
    assign bus.free_prf_2       = bus.rob_old_prf_2;
    assign bus.retire_cnt       = 2'(c1) + 2'(c2);
    assign bus.store_commit     = st;
    assign bus.flush            = flush_q;
    assign bus.rat_restore_en   = flush_q;
    assign bus.rat_restore_base = ARF_IDX'(32'(cnt) * CHUNK);
    assign bus.halted           = halted_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= NORMAL;
            cnt      <= '0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            unique case (state)
                NORMAL: begin
                    if ((c1 & bus.rob_mispred_1) | (c2 & bus.rob_mispred_2)) begin
                        state   <= RECOVER;
                        flush_q <= 1'b1;
                        cnt     <= '0;
                    end else if (c1 & bus.rob_halt_1) begin
                        state    <= HALTED;
                        halted_q <= 1'b1;
                    end else if (st) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.store_ack) state <= NORMAL;
                end
                RECOVER: begin
                    if (cnt == LAST) begin
                        state   <= NORMAL;
                        flush_q <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HALTED: ;
                default: state <= NORMAL;
            endcase
        end
    end
endmodule

// File: tb/tb_retire_ctrl.sv
// Self-checking bench for retire_ctrl: vector table plus
// scoreboarded multi-cycle store/recover/halt sequences.
module tb_retire_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    retire_ctrl_if #(.ARF_IDX(5), .PRF_IDX(6)) bus ();

    retire_ctrl #(
        .ARF_SIZE(32), .ARF_IDX(5), .PRF_IDX(6), .CHUNK(8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       v, d, hd, st, mp, ht;
        logic [4:0] dest;
        logic [5:0] prf, old;
    } slot_t;

    typedef struct {
        slot_t      s1, s2;
        logic       ack;
        logic       c1, c2;
        logic [1:0] cnt;
    } vec_t;

    typedef struct {
        logic [4:0] dest;
        logic [5:0] prf, old;
        logic       hd;
    } cm_t;

    int n_cmp = 0;
    int n_bad = 0;
    cm_t exp_q[$];
    logic [5:0] rrat [32];
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic slot_t rdy(input logic [4:0] dest,
                                  input logic [5:0] prf, input logic [5:0] old);
        slot_t s;
        s = '{v:1'b1, d:1'b1, hd:1'b1, st:1'b0, mp:1'b0, ht:1'b0,
              dest:dest, prf:prf, old:old};
        return s;
    endfunction

    task automatic set_slots(input slot_t a, input slot_t b, input logic ack);
        bus.rob_valid_1    = a.v;   bus.rob_done_1    = a.d;
        bus.rob_has_dest_1 = a.hd;  bus.rob_dest_1    = a.dest;
        bus.rob_prf_1      = a.prf; bus.rob_old_prf_1 = a.old;
        bus.rob_store_1    = a.st;  bus.rob_mispred_1 = a.mp;
        bus.rob_halt_1     = a.ht;
        bus.rob_valid_2    = b.v;   bus.rob_done_2    = b.d;
        bus.rob_has_dest_2 = b.hd;  bus.rob_dest_2    = b.dest;
        bus.rob_prf_2      = b.prf; bus.rob_old_prf_2 = b.old;
        bus.rob_store_2    = b.st;  bus.rob_mispred_2 = b.mp;
        bus.rob_halt_2     = b.ht;
        bus.store_ack      = ack;
    endtask

    task automatic exp_c(input slot_t s);
        exp_q.push_back('{dest:s.dest, prf:s.prf, old:s.old, hd:s.hd});
    endtask

    task automatic mon(input logic [4:0] dest, input logic [5:0] prf,
                       input logic [5:0] old, input logic fe);
        cm_t e;
        if (exp_q.size() == 0) begin
            chk("sb_extra_commit", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("sb_dest", 32'(dest), 32'(e.dest));
            chk("sb_prf", 32'(prf), 32'(e.prf));
            chk("sb_free_prf", 32'(old), 32'(e.old));
            chk("sb_free_en", 32'(fe), 32'(e.hd));
            rrat[dest] = prf;
        end
    endtask

    // Slot 1 updates first so a same-dest slot 2 write wins.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.commit_en_1)
                mon(bus.rrat_dest_1, bus.rrat_prf_1, bus.free_prf_1, bus.free_en_1);
            if (bus.commit_en_2)
                mon(bus.rrat_dest_2, bus.rrat_prf_2, bus.free_prf_2, bus.free_en_2);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        slot_t idle, a, b;
        idle = '{v:1'b0, d:1'b0, hd:1'b0, st:1'b0, mp:1'b0, ht:1'b0,
                 dest:5'd0, prf:6'd0, old:6'd0};
        for (int i = 0; i < 32; i++) rrat[i] = 6'(i);

        tbl[0] = '{s1:rdy(3, 40, 3), s2:rdy(7, 41, 7), ack:0, c1:1, c2:1, cnt:2};
        tbl[1] = '{s1:rdy(4, 42, 4), s2:rdy(5, 43, 5), ack:0, c1:1, c2:0, cnt:1};
        tbl[1].s2.d = 1'b0;
        tbl[2] = '{s1:rdy(6, 44, 6), s2:rdy(8, 45, 8), ack:1, c1:0, c2:0, cnt:0};
        tbl[2].s1.d = 1'b0;
        tbl[3] = '{s1:rdy(6, 44, 6), s2:rdy(8, 45, 8), ack:0, c1:0, c2:0, cnt:0};
        tbl[3].s1.v = 1'b0;
        tbl[4] = '{s1:rdy(0, 46, 0), s2:rdy(12, 47, 12), ack:0, c1:1, c2:1, cnt:2};
        tbl[4].s1.hd = 1'b0;
        tbl[5] = '{s1:rdy(9, 20, 10), s2:rdy(9, 21, 20), ack:0, c1:1, c2:1, cnt:2};
        tbl[6] = '{s1:rdy(13, 48, 13), s2:idle, ack:0, c1:1, c2:0, cnt:1};

        // Reset state; pass-through buses follow inputs during reset.
        set_slots(rdy(3, 40, 33), rdy(7, 41, 34), 1'b0);
        #2;
        chk("rst_commit_en_1", 32'(bus.commit_en_1), 0);
        chk("rst_retire_cnt", 32'(bus.retire_cnt), 0);
        chk("rst_flush", 32'(bus.flush), 0);
        chk("rst_halted", 32'(bus.halted), 0);
        chk("rst_base", 32'(bus.rat_restore_base), 0);
        chk("rst_pass_dest", 32'(bus.rrat_dest_2), 7);
        chk("rst_pass_old", 32'(bus.free_prf_1), 33);
        set_slots(idle, idle, 1'b0);
        #10 reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            set_slots(tbl[i].s1, tbl[i].s2, tbl[i].ack);
            #2;
            chk($sformatf("v%0d_c1", i), 32'(bus.commit_en_1), 32'(tbl[i].c1));
            chk($sformatf("v%0d_c2", i), 32'(bus.commit_en_2), 32'(tbl[i].c2));
            chk($sformatf("v%0d_cnt", i), 32'(bus.retire_cnt), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_st", i), 32'(bus.store_commit), 0);
            if (tbl[i].c1) exp_c(tbl[i].s1);
            if (tbl[i].c2) exp_c(tbl[i].s2);
            tick();
        end
        set_slots(idle, idle, 1'b0);
        chk("rrat3", 32'(rrat[3]), 40);
        chk("rrat7", 32'(rrat[7]), 41);
        chk("rrat9_slot2_wins", 32'(rrat[9]), 21);

        // Store serialisation.
        a = rdy(0, 0, 0); a.hd = 1'b0; a.st = 1'b1;
        set_slots(a, rdy(14, 49, 14), 1'b0);
        #2;
        chk("st_pulse", 32'(bus.store_commit), 1);
        chk("st_c1", 32'(bus.commit_en_1), 0);
        chk("st_cnt", 32'(bus.retire_cnt), 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stw_pulse", 32'(bus.store_commit), 0);
            chk("stw_c1", 32'(bus.commit_en_1), 0);
            tick();
        end
        bus.store_ack = 1'b1;
        #2;
        chk("ack_c1", 32'(bus.commit_en_1), 1);
        chk("ack_c2", 32'(bus.commit_en_2), 0);
        chk("ack_cnt", 32'(bus.retire_cnt), 1);
        exp_c(a);
        tick();
        set_slots(rdy(14, 49, 14), idle, 1'b0);
        #2;
        chk("post_st_c1", 32'(bus.commit_en_1), 1);
        chk("post_st_pulse", 32'(bus.store_commit), 0);
        exp_c(rdy(14, 49, 14));
        tick();

        // Slot 1 mispredict: only slot 1 commits, 4 restore chunks.
        a = rdy(5, 50, 15); a.mp = 1'b1;
        set_slots(a, rdy(16, 51, 16), 1'b0);
        #2;
        chk("mp1_c1", 32'(bus.commit_en_1), 1);
        chk("mp1_c2", 32'(bus.commit_en_2), 0);
        chk("mp1_flush0", 32'(bus.flush), 0);
        exp_c(a);
        tick();
        set_slots(rdy(16, 51, 16), rdy(17, 52, 17), 1'b0);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("rec_flush", 32'(bus.flush), 1);
            chk("rec_en", 32'(bus.rat_restore_en), 1);
            chk("rec_base", 32'(bus.rat_restore_base), 32'(i * 8));
            chk("rec_cnt", 32'(bus.retire_cnt), 0);
            tick();
        end
        #2;
        chk("rec_done_flush", 32'(bus.flush), 0);
        chk("rec_done_cnt", 32'(bus.retire_cnt), 2);
        exp_c(rdy(16, 51, 16));
        exp_c(rdy(17, 52, 17));
        chk("rrat5", 32'(rrat[5]), 50);
        tick();

        // Slot 2 mispredict, then reset partway through recovery.
        b = rdy(2, 31, 18); b.mp = 1'b1;
        set_slots(rdy(1, 30, 19), b, 1'b0);
        #2;
        chk("mp2_cnt", 32'(bus.retire_cnt), 2);
        exp_c(rdy(1, 30, 19));
        exp_c(b);
        tick();
        set_slots(rdy(11, 53, 11), idle, 1'b0);
        #2;
        chk("mp2_base0", 32'(bus.rat_restore_base), 0);
        tick();
        #2;
        chk("mp2_base8", 32'(bus.rat_restore_base), 8);
        reset = 1'b1;
        #1;
        chk("arst_flush", 32'(bus.flush), 0);
        chk("arst_en", 32'(bus.rat_restore_en), 0);
        chk("arst_base", 32'(bus.rat_restore_base), 0);
        chk("arst_c1", 32'(bus.commit_en_1), 0);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("post_rst_c1", 32'(bus.commit_en_1), 1);
        chk("post_rst_flush", 32'(bus.flush), 0);
        chk("post_rst_base", 32'(bus.rat_restore_base), 0);
        exp_c(rdy(11, 53, 11));
        tick();

        // Halt: slot 1 only, then sticky until reset.
        a = rdy(8, 33, 21); a.ht = 1'b1;
        set_slots(a, rdy(9, 34, 22), 1'b0);
        #2;
        chk("halt_c1", 32'(bus.commit_en_1), 1);
        chk("halt_c2", 32'(bus.commit_en_2), 0);
        chk("halt_pre", 32'(bus.halted), 0);
        exp_c(a);
        tick();
        set_slots(rdy(9, 34, 22), rdy(10, 35, 23), 1'b0);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("halted", 32'(bus.halted), 1);
            chk("halted_cnt", 32'(bus.retire_cnt), 0);
            chk("halted_flush", 32'(bus.flush), 0);
            tick();
        end
        set_slots(idle, idle, 1'b0);
        reset = 1'b1;
        #2;
        chk("halt_rst", 32'(bus.halted), 0);
        reset = 1'b0;
        tick();
        tick();
        chk("sb_left", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
